// File: rtl/path_reader_pkg.sv
// Shared definitions for path_reader: FSM state encodings and the default coordinate width.
package path_reader_pkg;

  localparam int unsigned COORD_W_DEFAULT = 4;

  typedef logic [2:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StPop  = 3'd1;
  localparam state_t StWait = 3'd2;
  localparam state_t StEmit = 3'd3;
  localparam state_t StDone = 3'd4;

endpackage

// File: rtl/path_buffer.sv
// DEPTH x WIDTH register file holding drained path entries; synchronous write, asynchronous read.
module path_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/path_reader.sv
// Drains the coordinate stack and streams (x, y) pairs over valid/ready.
// PATH_REPLAY_FORWARD_EN selects buffered forward replay; otherwise entries stream goal-to-start.
module path_reader
  import path_reader_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned COORD_W = COORD_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               pop,
  input  logic [COORD_W-1:0] stkX,
  input  logic [COORD_W-1:0] stkY,
  input  logic               stkFail,
  output logic [COORD_W-1:0] xOut,
  output logic [COORD_W-1:0] yOut,
  output logic               valid,
  input  logic               ready,
  output logic               done,
  output logic               overflow
);

  state_t state_q, state_d;

`ifdef PATH_REPLAY_FORWARD_EN

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
  localparam logic [AW-1:0] LastIdx  = AW'(DEPTH - 1);

  logic [CW-1:0]          count_q, count_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic                   overflow_q, overflow_d;
  logic                   buf_we;
  logic [2*COORD_W-1:0]   buf_rdata;

  path_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (2 * COORD_W)
  ) u_path_buffer (
    .clk   (clk),
    .we    (buf_we),
    .waddr (count_q[AW-1:0]),
    .wdata ({stkX, stkY}),
    .raddr (idx_q),
    .rdata (buf_rdata)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    overflow_d = overflow_q;
    buf_we     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          count_d    = '0;
          overflow_d = 1'b0;
          state_d    = StPop;
        end
      end
      StPop: state_d = StWait;
      StWait: begin
        if (stkFail) begin
          if (count_q != '0) begin
            idx_d   = AW'(count_q - 1'b1);
            state_d = StEmit;
          end else begin
            state_d = StDone;
          end
        end else if (count_q < DepthCnt) begin
          buf_we  = 1'b1;
          count_d = count_q + 1'b1;
          state_d = StPop;
        end else begin
          // Stack deeper than the buffer: keep what fits, leave the rest on the stack.
          overflow_d = 1'b1;
          idx_d      = LastIdx;
          state_d    = StEmit;
        end
      end
      StEmit: begin
        if (ready) begin
          if (idx_q == '0) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
    end
  end

  assign {xOut, yOut} = valid ? buf_rdata : '0;
  assign overflow     = overflow_q;

`else

  logic [2*COORD_W-1:0] hold_q, hold_d;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StPop;
        end
      end
      StPop: state_d = StWait;
      StWait: begin
        if (stkFail) begin
          state_d = StDone;
        end else begin
          hold_d  = {stkX, stkY};
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (ready) begin
          state_d = StPop;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign {xOut, yOut} = valid ? hold_q : '0;
  assign overflow     = 1'b0;

`endif

  assign pop   = (state_q == StPop);
  assign valid = (state_q == StEmit);
  assign done  = (state_q == StDone);

endmodule
